legv8_multicycle_control: RTL and testbench



---
 rtl/legv8_multicycle_control_pkg.sv | 42 ++++
 rtl/legv8_multicycle_control_if.sv | 40 ++++
 rtl/legv8_multicycle_control_classify.sv | 35 +++
 rtl/legv8_multicycle_control.sv | 152 +++++++++++++++
 tb/tb_legv8_multicycle_control.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_multicycle_control_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle control unit.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILL  = 3'd0,
        CLS_R    = 3'd1,
        CLS_LDUR = 3'd2,
        CLS_STUR = 3'd3,
        CLS_CBZ  = 3'd4,
        CLS_CBNZ = 3'd5,
        CLS_B    = 3'd6
    } cls_e;

    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [6:0]  OP_CB_HI  = 7'b1011010;   // bit 3 below this selects CBNZ
    localparam logic [5:0]  OP_B      = 6'b000101;
    localparam logic [3:0]  OP_R_MID  = 4'b0101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_BRANCH = 2'b10;

endpackage

// File: rtl/legv8_multicycle_control_if.sv
// Control-unit bundle: memory handshake, instruction field, datapath controls and status.
interface legv8_multicycle_control_if #(
    parameter int OPCODE_W = 11
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ack;
    logic                mem_req;
    logic                mem_read;
    logic                mem_write;
    logic                iord;
    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic                reg2loc;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_src;
    logic                branch_nz;
    logic                illegal;
    logic                bus_error;
    logic [2:0]          state_o;

    modport master (
        input  opcode, zero, mem_ack,
        output mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
               reg2loc, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
               branch_nz, illegal, bus_error, state_o
    );

    modport slave (
        output opcode, zero, mem_ack,
        input  mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
               reg2loc, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
               branch_nz, illegal, bus_error, state_o
    );
endinterface

// File: rtl/legv8_multicycle_control_classify.sv
// Combinational opcode classifier; disabled classes fall through to illegal.
module legv8_opcode_classify
    import legv8_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 11,
    parameter bit ENABLE_CBNZ = 1'b1,
    parameter bit ENABLE_B    = 1'b1
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output cls_e                cls_o,
    output logic                illegal_o
);

    logic [10:0] op;
    assign op = opcode_i[OPCODE_W-1 -: 11];

    always_comb begin
        cls_o = CLS_ILL;
        if (op == OP_LDUR) begin
            cls_o = CLS_LDUR;
        end else if (op == OP_STUR) begin
            cls_o = CLS_STUR;
        end else if (op[10:4] == OP_CB_HI) begin
            if (!op[3])          cls_o = CLS_CBZ;
            else if (ENABLE_CBNZ) cls_o = CLS_CBNZ;
        end else if (op[10:5] == OP_B) begin
            if (ENABLE_B) cls_o = CLS_B;
        end else if (op[10] && op[7:4] == OP_R_MID && op[2:0] == 3'b000) begin
            cls_o = CLS_R;
        end
    end

    assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/legv8_multicycle_control.sv
// LEGv8 multi-cycle control FSM with req/ack memory handshake, illegal-opcode and timeout traps.
module legv8_multicycle_control
    import legv8_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 11,
    parameter bit ENABLE_CBNZ = 1'b1,
    parameter bit ENABLE_B    = 1'b1,
    parameter int MEM_TIMEOUT = 0
) (
    input logic                        clk,
    input logic                        rst_n,
    legv8_multicycle_control_if.master bus
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e           state_q;
    cls_e             cls_q;
    cls_e             cls_d;
    logic             illegal_d;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal_q;
    logic             bus_error_q;
    logic             timeout;

    legv8_opcode_classify #(
        .OPCODE_W   (OPCODE_W),
        .ENABLE_CBNZ(ENABLE_CBNZ),
        .ENABLE_B   (ENABLE_B)
    ) u_classify (
        .opcode_i (bus.opcode),
        .cls_o    (cls_d),
        .illegal_o(illegal_d)
    );

    // An ack in the cycle the count hits the limit takes priority over the trap.
    assign timeout = (MEM_TIMEOUT > 0) && !bus.mem_ack && (cnt_q == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            cls_q       <= CLS_ILL;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH, ST_MEM: begin
                    if (bus.mem_ack) begin
                        cnt_q <= '0;
                        if (state_q == ST_FETCH)     state_q <= ST_DECODE;
                        else if (cls_q == CLS_LDUR)  state_q <= ST_WB;
                        else                         state_q <= ST_FETCH;
                    end else if (timeout) begin
                        bus_error_q <= 1'b1;
                        state_q     <= ST_TRAP;
                    end else if (MEM_TIMEOUT > 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    cls_q <= cls_d;
                    if (illegal_d) begin
                        illegal_q <= 1'b1;
                        state_q   <= ST_TRAP;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    cnt_q <= '0;
                    case (cls_q)
                        CLS_R:              state_q <= ST_WB;
                        CLS_LDUR, CLS_STUR: state_q <= ST_MEM;
                        default:            state_q <= ST_FETCH;
                    endcase
                end
                ST_WB:   state_q <= ST_FETCH;
                default: state_q <= state_q;
            endcase
        end
    end

    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.reg2loc       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALUOP_ADD;
        bus.pc_src        = PCSRC_ALU;
        bus.branch_nz     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ack;
                bus.pc_write  = bus.mem_ack;
            end
            ST_DECODE: bus.alu_src_b = SRCB_IMM_SH;
            ST_EXEC: begin
                case (cls_q)
                    CLS_R: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_op    = ALUOP_FUNCT;
                    end
                    CLS_LDUR, CLS_STUR: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = SRCB_IMM;
                        bus.reg2loc   = 1'b1;
                    end
                    CLS_CBZ, CLS_CBNZ: begin
                        bus.reg2loc       = 1'b1;
                        bus.alu_op        = ALUOP_PASSB;
                        bus.pc_write_cond = 1'b1;
                        bus.pc_src        = PCSRC_ALUOUT;
                        bus.branch_nz     = (cls_q == CLS_CBNZ);
                    end
                    CLS_B: begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = PCSRC_ALUOUT;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                bus.mem_req   = 1'b1;
                bus.iord      = 1'b1;
                bus.mem_read  = (cls_q == CLS_LDUR);
                bus.mem_write = (cls_q == CLS_STUR);
            end
            ST_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (cls_q == CLS_LDUR);
            end
            default: ;
        endcase
    end

    assign bus.illegal   = illegal_q;
    assign bus.bus_error = bus_error_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Scoreboard bench: per-cycle expected control vectors queued by the driver, popped at negedge.
module tb_legv8_multicycle_control;
    import legv8_ctrl_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
        logic reg2loc, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic branch_nz, illegal, bus_error;
    } row_t;

    typedef struct {
        row_t  row;
        string tag;
    } sb_t;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_CBNZ = 4, K_B = 5, K_ILL = 6;
    localparam int TO_LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] opcode_d;
    logic        zero_d;
    logic        mem_ack_d;
    int          sel;
    int          n_vec = 0;
    int          n_err = 0;
    logic        ill_m, berr_m;
    sb_t         exp_q[$];
    row_t        obs0, obs1, obs2, obs_sel;

    always #5 clk = ~clk;

    legv8_multicycle_control_if #(.OPCODE_W(11)) bus0 ();
    legv8_multicycle_control_if #(.OPCODE_W(11)) bus1 ();
    legv8_multicycle_control_if #(.OPCODE_W(11)) bus2 ();

    legv8_multicycle_control #(.OPCODE_W(11), .ENABLE_CBNZ(1'b1), .ENABLE_B(1'b1), .MEM_TIMEOUT(0))
        dut_base (.clk(clk), .rst_n(rst_n), .bus(bus0));
    legv8_multicycle_control #(.OPCODE_W(11), .ENABLE_CBNZ(1'b0), .ENABLE_B(1'b1), .MEM_TIMEOUT(0))
        dut_nocbnz (.clk(clk), .rst_n(rst_n), .bus(bus1));
    legv8_multicycle_control #(.OPCODE_W(11), .ENABLE_CBNZ(1'b1), .ENABLE_B(1'b1), .MEM_TIMEOUT(TO_LIM))
        dut_to (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.opcode = opcode_d; assign bus0.zero = zero_d; assign bus0.mem_ack = mem_ack_d;
    assign bus1.opcode = opcode_d; assign bus1.zero = zero_d; assign bus1.mem_ack = mem_ack_d;
    assign bus2.opcode = opcode_d; assign bus2.zero = zero_d; assign bus2.mem_ack = mem_ack_d;

    assign obs0 = {bus0.state_o, bus0.mem_req, bus0.mem_read, bus0.mem_write, bus0.iord, bus0.ir_write,
                   bus0.pc_write, bus0.pc_write_cond, bus0.reg2loc, bus0.mem_to_reg, bus0.reg_write,
                   bus0.alu_src_a, bus0.alu_src_b, bus0.alu_op, bus0.pc_src, bus0.branch_nz,
                   bus0.illegal, bus0.bus_error};
    assign obs1 = {bus1.state_o, bus1.mem_req, bus1.mem_read, bus1.mem_write, bus1.iord, bus1.ir_write,
                   bus1.pc_write, bus1.pc_write_cond, bus1.reg2loc, bus1.mem_to_reg, bus1.reg_write,
                   bus1.alu_src_a, bus1.alu_src_b, bus1.alu_op, bus1.pc_src, bus1.branch_nz,
                   bus1.illegal, bus1.bus_error};
    assign obs2 = {bus2.state_o, bus2.mem_req, bus2.mem_read, bus2.mem_write, bus2.iord, bus2.ir_write,
                   bus2.pc_write, bus2.pc_write_cond, bus2.reg2loc, bus2.mem_to_reg, bus2.reg_write,
                   bus2.alu_src_a, bus2.alu_src_b, bus2.alu_op, bus2.pc_src, bus2.branch_nz,
                   bus2.illegal, bus2.bus_error};
    assign obs_sel = (sel == 0) ? obs0 : (sel == 1) ? obs1 : obs2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for one cycle, written from the control-table description.
    function automatic row_t spec_row(input state_e st, input int kind, input logic ack);
        row_t r;
        r = '0;
        r.st = st;
        r.illegal = ill_m;
        r.bus_error = berr_m;
        case (st)
            ST_FETCH: begin
                r.mem_req = 1'b1; r.mem_read = 1'b1; r.alu_src_b = 2'b01;
                r.ir_write = ack; r.pc_write = ack;
            end
            ST_DECODE: r.alu_src_b = 2'b11;
            ST_EXEC: begin
                if (kind == K_R) begin
                    r.alu_src_a = 1'b1; r.alu_op = 2'b10;
                end else if (kind == K_LD || kind == K_ST) begin
                    r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; r.reg2loc = 1'b1;
                end else if (kind == K_CBZ || kind == K_CBNZ) begin
                    r.reg2loc = 1'b1; r.alu_op = 2'b01; r.pc_write_cond = 1'b1;
                    r.pc_src = 2'b01; r.branch_nz = (kind == K_CBNZ);
                end else if (kind == K_B) begin
                    r.pc_write = 1'b1; r.pc_src = 2'b01;
                end
            end
            ST_MEM: begin
                r.mem_req = 1'b1; r.iord = 1'b1;
                r.mem_read = (kind == K_LD); r.mem_write = (kind == K_ST);
            end
            ST_WB: begin
                r.reg_write = 1'b1; r.mem_to_reg = (kind == K_LD);
            end
            default: ;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        sb_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(e.tag, 32'(obs_sel), 32'(e.row));
        end
    end

    task automatic step(input state_e st, input int kind, input logic ack, input string tag);
        mem_ack_d = ack;
        exp_q.push_back('{row: spec_row(st, kind, ack), tag: tag});
        @(posedge clk);
        #1;
    endtask

    // A stale ack held through reset must not advance the FSM.
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ack_d = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_ack_d = 1'b0;
        rst_n = 1'b1;
        ill_m = 1'b0;
        berr_m = 1'b0;
        #1;
        check("reset", 32'(obs_sel), 32'(spec_row(ST_FETCH, K_R, 1'b0)));
    endtask

    task automatic run_instr(input logic [10:0] op, input int kind, input int fwait,
                             input int mwait, input bit mhang, input int trap_n);
        int mlen;
        for (int i = 0; i <= fwait; i++) begin
            opcode_d = 11'($urandom);
            step(ST_FETCH, kind, (i == fwait), "fetch");
        end
        opcode_d = op;
        step(ST_DECODE, kind, 1'b0, "decode");
        if (kind == K_ILL) begin
            ill_m = 1'b1;
            for (int i = 0; i < trap_n; i++) step(ST_TRAP, kind, 1'b0, "trap_ill");
            return;
        end
        step(ST_EXEC, kind, 1'b0, "exec");
        if (kind == K_LD || kind == K_ST) begin
            mlen = mhang ? TO_LIM : mwait;
            for (int i = 0; i <= mlen; i++) step(ST_MEM, kind, !mhang && (i == mlen), "mem");
            if (mhang) begin
                berr_m = 1'b1;
                for (int i = 0; i < trap_n; i++) step(ST_TRAP, kind, 1'b0, "trap_mem_to");
                return;
            end
        end
        if (kind == K_R || kind == K_LD) step(ST_WB, kind, 1'b0, "wb");
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : driver
        logic [10:0] op;
        int          k;
        rst_n = 1'b0; opcode_d = '0; zero_d = 1'b0; mem_ack_d = 1'b0; sel = 0;
        ill_m = 1'b0; berr_m = 1'b0;
        do_reset();

        // Directed: zero-wait ADD, slow LDUR, STUR, CBNZ with zero=0, CBZ, B.
        run_instr(11'b10001011000, K_R, 0, 0, 1'b0, 0);
        run_instr(11'b11111000010, K_LD, 0, 3, 1'b0, 0);
        run_instr(11'b11111000000, K_ST, 1, 0, 1'b0, 0);
        zero_d = 1'b0;
        run_instr(11'b10110101011, K_CBNZ, 0, 0, 1'b0, 0);
        zero_d = 1'b1;
        run_instr(11'b10110100101, K_CBZ, 2, 0, 1'b0, 0);
        run_instr(11'b00010110110, K_B, 0, 0, 1'b0, 0);

        // Random mix with variable fetch/data latency.
        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: begin op = 11'b10001011000; if ($urandom_range(0, 1) == 1) op = 11'b11001011000; end
                1: op = 11'b11111000010;
                2: op = 11'b11111000000;
                3: begin op = 11'b10110100000; op[2:0] = 3'($urandom); end
                4: begin op = 11'b10110101000; op[2:0] = 3'($urandom); end
                default: begin op = 11'b00010100000; op[4:0] = 5'($urandom); end
            endcase
            zero_d = 1'($urandom);
            run_instr(op, k, $urandom_range(0, 6), $urandom_range(0, 5), 1'b0, 0);
        end
        run_instr(11'b10101010000, K_R, 0, 0, 1'b0, 0);

        // Undefined opcode traps and stays put; reset clears the sticky flag.
        run_instr(11'b00000000000, K_ILL, 0, 0, 1'b0, 10);
        do_reset();
        run_instr(11'b10001010000, K_R, 0, 0, 1'b0, 0);

        // Reset in the second cycle of a STUR data wait.
        opcode_d = 11'($urandom);
        step(ST_FETCH, K_ST, 1'b1, "st_fetch");
        opcode_d = 11'b11111000000;
        step(ST_DECODE, K_ST, 1'b0, "st_decode");
        step(ST_EXEC, K_ST, 1'b0, "st_exec");
        step(ST_MEM, K_ST, 1'b0, "st_mem0");
        mem_ack_d = 1'b0;
        #2;
        check("st_mem1_write", 32'(bus0.mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_mem_write", 32'(bus0.mem_write), 32'd0);
        check("rst_async_iord", 32'(bus0.iord), 32'd0);
        check("rst_async_state", 32'(bus0.state_o), 32'(ST_FETCH));
        do_reset();
        run_instr(11'b11111000000, K_ST, 0, 0, 1'b0, 0);

        // CBNZ disabled: CBZ still decodes, CBNZ traps as illegal.
        sel = 1;
        do_reset();
        run_instr(11'b10110100000, K_CBZ, 0, 0, 1'b0, 0);
        run_instr(11'b10110101000, K_ILL, 0, 0, 1'b0, 3);

        // Timeout of 4: counts 0..4 without ack trap; ack at count 4 wins.
        sel = 2;
        do_reset();
        for (int i = 0; i <= TO_LIM; i++) step(ST_FETCH, K_R, 1'b0, "fetch_to");
        berr_m = 1'b1;
        for (int i = 0; i < 3; i++) step(ST_TRAP, K_R, 1'b0, "trap_fetch_to");
        do_reset();
        run_instr(11'b10001011000, K_R, TO_LIM, 0, 1'b0, 0);
        run_instr(11'b11111000010, K_LD, 0, TO_LIM, 1'b0, 0);
        run_instr(11'b11111000010, K_LD, 1, 0, 1'b1, 3);
        do_reset();
        run_instr(11'b00010100001, K_B, 3, 0, 1'b0, 0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
